// File: rtl/decoder2_seq_if.sv
// ============================================================================
// decoder2_seq_if : code-input handshake and decoded-line outputs
// Revision 1.0
// ============================================================================
`default_nettype none

interface decoder2_seq_if;
  logic in_valid;
  logic in_ready;
  logic none_on;
  logic in2;
  logic in1;
  logic in0;
  logic h;
  logic g;
  logic f;
  logic e;
  logic d;
  logic c;
  logic b;
  logic a;
  logic out_valid;
  logic none_out;

  modport master (
    output in_valid, none_on, in2, in1, in0,
    input  in_ready, h, g, f, e, d, c, b, a, out_valid, none_out
  );

  modport slave (
    input  in_valid, none_on, in2, in1, in0,
    output in_ready, h, g, f, e, d, c, b, a, out_valid, none_out
  );
endinterface

`default_nettype wire

// File: rtl/decoder2_seq.sv
// ============================================================================
// decoder2_seq : buffered 3-to-8 decoder replaying codes as timed one-hot pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module decoder2_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  decoder2_seq_if.slave bus
);

  localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [3:0] c_GAP_LOAD  = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mem_q [2];
  logic [3:0]  mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  line_q, line_d;
  logic        out_valid_q, out_valid_d;
  logic        none_out_q, none_out_d;

  logic        w_ready;
  logic        w_push;
  logic        w_pop;
  logic        w_load;
  logic        w_blank;
  logic        w_nonempty;
  logic [3:0]  w_head;

  assign w_ready    = (count_q != 2'd2);
  assign w_push     = bus.in_valid && w_ready;
  assign w_pop      = w_load;
  assign w_nonempty = (count_q != 2'd0);
  assign w_head     = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ w_push;
    rd_ptr_d = rd_ptr_q ^ w_pop;
    count_d  = count_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = {bus.none_on, bus.in2, bus.in1, bus.in0};
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    line_d      = line_q;
    out_valid_d = out_valid_q;
    none_out_d  = none_out_q;
    w_load      = 1'b0;
    w_blank     = 1'b0;

    case (state_q)
      S_IDLE: begin
        w_blank = 1'b1;
        w_load  = w_nonempty;
      end
      S_DRIVE: begin
        if (hold_cnt_q != 8'd0) begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end else if (GAP != 0) begin
          state_d   = S_GAP;
          gap_cnt_d = c_GAP_LOAD;
          w_blank   = 1'b1;
        end else if (w_nonempty) begin
          w_load = 1'b1;
        end else begin
          state_d = S_IDLE;
          w_blank = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (w_nonempty) begin
          w_load = 1'b1;
        end else begin
          state_d = S_IDLE;
          w_blank = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        w_blank = 1'b1;
      end
    endcase

    if (w_blank) begin
      line_d      = 8'd0;
      out_valid_d = 1'b0;
      none_out_d  = 1'b0;
    end
    // A load always opens a fresh window, overriding any blanking above.
    if (w_load) begin
      state_d     = S_DRIVE;
      hold_cnt_d  = c_HOLD_LOAD;
      line_d      = w_head[3] ? 8'd0 : (8'd1 << w_head[2:0]);
      out_valid_d = 1'b1;
      none_out_d  = w_head[3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_q[0]    <= 4'd0;
      mem_q[1]    <= 4'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      hold_cnt_q  <= 8'd0;
      gap_cnt_q   <= 4'd0;
      line_q      <= 8'd0;
      out_valid_q <= 1'b0;
      none_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      line_q      <= line_d;
      out_valid_q <= out_valid_d;
      none_out_q  <= none_out_d;
    end
  end

  assign bus.in_ready  = w_ready;
  assign {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = line_q;
  assign bus.out_valid = out_valid_q;
  assign bus.none_out  = none_out_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder2_seq.sv
// ============================================================================
// tb_decoder2_seq : directed stimulus on two parameterisations, window-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_decoder2_seq;

  logic clk;
  logic rst;
  logic       drv_valid [2];
  logic [3:0] drv_code  [2];
  logic [10:0] obs [2];   // {in_ready, none_out, out_valid, h..a}

  int errors = 0;
  int checks = 0;
  bit started = 0;
  bit prev_ov0 = 0;
  int seen0 [$];

  localparam int HOLD_P [2] = '{4, 1};
  localparam int GAP_P  [2] = '{1, 0};

  decoder2_seq_if bus0 ();
  decoder2_seq_if bus1 ();

  decoder2_seq #(.HOLD(4), .GAP(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  decoder2_seq #(.HOLD(1), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.in_valid = drv_valid[0];
  assign {bus0.none_on, bus0.in2, bus0.in1, bus0.in0} = drv_code[0];
  assign bus1.in_valid = drv_valid[1];
  assign {bus1.none_on, bus1.in2, bus1.in1, bus1.in0} = drv_code[1];
  assign obs[0] = {bus0.in_ready, bus0.none_out, bus0.out_valid,
                   bus0.h, bus0.g, bus0.f, bus0.e, bus0.d, bus0.c, bus0.b, bus0.a};
  assign obs[1] = {bus1.in_ready, bus1.none_out, bus1.out_valid,
                   bus1.h, bus1.g, bus1.f, bus1.e, bus1.d, bus1.c, bus1.b, bus1.a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a queue of waiting codes plus remaining window / gap cycle counts.
  int         m_drv [2];
  int         m_gap [2];
  int         m_cnt [2];
  logic [3:0] m_cur [2];
  logic [3:0] m_q   [2][2];

  task automatic model_step(int i);
    bit acc;
    acc = drv_valid[i] && (m_cnt[i] < 2);
    if (m_drv[i] > 0) begin
      m_drv[i]--;
      if (m_drv[i] == 0) m_gap[i] = GAP_P[i];
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
    end
    if (m_drv[i] == 0 && m_gap[i] == 0 && m_cnt[i] > 0) begin
      m_cur[i]    = m_q[i][0];
      m_q[i][0]   = m_q[i][1];
      m_cnt[i]--;
      m_drv[i]    = HOLD_P[i];
    end
    if (acc) begin
      m_q[i][m_cnt[i]] = drv_code[i];
      m_cnt[i]++;
    end
  endtask

  function automatic int exp_obs(int i);
    bit ov;
    logic [7:0] lines;
    ov    = (m_drv[i] > 0);
    lines = (ov && !m_cur[i][3]) ? (8'd1 << m_cur[i][2:0]) : 8'd0;
    return int'({(m_cnt[i] < 2), (ov && m_cur[i][3]), ov, lines});
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_drv[i] = 0; m_gap[i] = 0; m_cnt[i] = 0; m_cur[i] = 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && started) begin
      chk("model0", int'(obs[0]), exp_obs(0));
      chk("model1", int'(obs[1]), exp_obs(1));
      if (obs[0][8] && !prev_ov0) seen0.push_back(int'(obs[0][7:0]));
      prev_ov0 = obs[0][8];
    end else begin
      prev_ov0 = 1'b0;
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [2:0] bp_codes [4];
    int idx;
    int cyc;
    bit acc_pred;
    bp_codes = '{3'd7, 3'd6, 3'd5, 3'd4};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_code[i]  = 4'd0;
    end
    idle(2);
    chk("reset_state0", int'(obs[0]), 'h400);
    chk("reset_state1", int'(obs[1]), 'h400);
    rst = 1'b0;
    started = 1'b1;
    idle(2);

    // Single code f
    drv_valid[0] = 1'b1; drv_code[0] = 4'b0101;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    chk("single_edge0", int'(obs[0]), 'h400);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("single_hold", int'(obs[0]), 'h520);
    end
    @(negedge clk);
    chk("single_end", int'(obs[0]), 'h400);
    idle(3);

    // none_on code
    drv_valid[0] = 1'b1; drv_code[0] = 4'b1011;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("none_hold", int'(obs[0]), 'h700);
    end
    @(negedge clk);
    chk("none_end", int'(obs[0]), 'h400);
    idle(3);

    // Back-pressure with in_valid held high
    seen0.delete();
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 60) begin
      drv_valid[0] = 1'b1;
      drv_code[0]  = {1'b0, bp_codes[idx]};
      acc_pred     = (m_cnt[0] < 2);
      @(negedge clk);
      if (acc_pred) begin
        idx++;
        if (idx == 3) chk("bp_ready_drop", int'(obs[0][10]), 0);
      end
      cyc++;
    end
    drv_valid[0] = 1'b0;
    chk("bp_all_accepted", idx, 4);
    idle(30);
    chk("bp_count", seen0.size(), 4);
    if (seen0.size() == 4) begin
      chk("bp_h", seen0[0], 'h80);
      chk("bp_g", seen0[1], 'h40);
      chk("bp_f", seen0[2], 'h20);
      chk("bp_e", seen0[3], 'h10);
    end

    // HOLD=1, GAP=0 instance: abutting windows
    drv_valid[1] = 1'b1; drv_code[1] = 4'd0;
    @(negedge clk);
    chk("b2b_edge0", int'(obs[1]), 'h400);
    drv_code[1] = 4'd1;
    @(negedge clk);
    chk("b2b_a", int'(obs[1]), 'h501);
    drv_code[1] = 4'd2;
    @(negedge clk);
    chk("b2b_b", int'(obs[1]), 'h502);
    drv_valid[1] = 1'b0;
    @(negedge clk);
    chk("b2b_c", int'(obs[1]), 'h504);
    @(negedge clk);
    chk("b2b_end", int'(obs[1]), 'h400);
    idle(3);

    // Reset during the second DRIVE cycle with two codes buffered
    drv_valid[0] = 1'b1; drv_code[0] = 4'd3;
    @(negedge clk);
    drv_code[0] = 4'd2;
    @(negedge clk);
    drv_code[0] = 4'd1;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    chk("rst_pre_full", int'(obs[0]), 'h108);
    #1 rst = 1'b1;
    #1 chk("rst_async", int'(obs[0]), 'h400);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_stale", int'(obs[0]), 'h400);
    end
    drv_valid[0] = 1'b1; drv_code[0] = 4'd6;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    chk("rst_new_edge0", int'(obs[0]), 'h400);
    @(negedge clk);
    chk("rst_new_lat1", int'(obs[0]), 'h540);
    idle(8);

    // Push and pop on the same edge at a window boundary
    seen0.delete();
    drv_valid[0] = 1'b1; drv_code[0] = 4'd1;
    @(negedge clk);
    drv_code[0] = 4'd2;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    idle(4);
    drv_valid[0] = 1'b1; drv_code[0] = 4'd3;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    chk("pushpop_count1", int'(obs[0]), 'h504);
    idle(20);
    chk("pushpop_count", seen0.size(), 3);
    if (seen0.size() == 3) begin
      chk("pushpop_b", seen0[0], 'h02);
      chk("pushpop_c", seen0[1], 'h04);
      chk("pushpop_d", seen0[2], 'h08);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoder2_seq.md
# decoder2_seq

Sequenced 3-to-8 line decoder: the receive-side counterpart of the priority encoder. Accepts encoded codes ({none_on, in2, in1, in0}) through a valid/ready handshake into a 2-entry buffer. Replays each code as a one-hot pulse on lines a..h, held for a programmable number of cycles and separated by a programmable idle gap. Used wherever an encoded event index is turned back into discrete strobes.

## Interface

**Parameters**
- HOLD, 4: cycles each decoded line is held high; legal 1..255.
- GAP, 1: idle cycles after each hold window; legal 0..15.

**Ports**
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: code present on the input.
- in_ready, output, 1: the buffer can accept a code.
- none_on, input, 1: code carries no active line.
- in2, in1, in0, input, 1 each: encoded index, with in2 as the MSB; 0 = a, 7 = h.
- h, g, f, e, d, c, b, a, output, 1 each: decoded one-hot lines.
- out_valid, output, 1: a hold window is in progress.
- none_out, output, 1: the current window carries a none_on code.

## Operation

- **Accept:** a code is accepted on a rising edge where in_valid && in_ready.
- **Buffer:** 2-entry FIFO of 4-bit codes with a 2-bit count.
  - in_ready = (count != 2); it is a combinational decode of registered state only.
  - Push and pop in the same cycle leave the count unchanged.
  - The buffer never overflows: no push occurs when count = 2.
- **State machine:** states IDLE, DRIVE, GAP.
- **IDLE:**
  - Outputs are low.
  - If count != 0: pop the head, load the line register, set hold_cnt = HOLD-1, and go to DRIVE.
- **DRIVE:**
  - Line register drives h..a; out_valid = 1; none_out = the stored none_on bit.
  - If none_on = 1, all eight lines are 0 and out_valid = 1.
  - hold_cnt decrements each cycle. When hold_cnt = 0:
    - GAP > 0: go to GAP with gap_cnt = GAP-1.
    - GAP = 0 and buffer non-empty: pop and reload, staying in DRIVE (back-to-back windows, no idle cycle).
    - GAP = 0 and buffer empty: go to IDLE.
- **GAP:**
  - Outputs are low.
  - gap_cnt decrements each cycle. When gap_cnt = 0: if the buffer is non-empty, pop, load and go to DRIVE; otherwise go to IDLE.
- **Decode rule:** line k is high iff none_on = 0 and {in2,in1,in0} = k, with a = 0 through h = 7. At most one line is ever high.
- **Output registers:** h..a, out_valid and none_out are all registered; no combinational path from inputs to these outputs.
- **Reset:** asynchronous, effective immediately, including mid-DRIVE or mid-GAP.
  - FIFO count = 0, state = IDLE.
  - h..a = 0, out_valid = 0, none_out = 0, counters = 0.
  - in_ready = 1 once rst deasserts.
  - Any buffered codes are discarded.

## Timing

- **Latency:** code accepted at edge N with the buffer empty and the FSM in IDLE → written to the FIFO at N → popped at N+1 → decoded line high from N+1 for exactly HOLD cycles.
- **Window length:** each window is exactly HOLD cycles with out_valid = 1.
- **Window spacing:** consecutive windows are separated by exactly GAP cycles with all outputs low. With GAP = 0 they abut.
- **Throughput:** one code per HOLD+GAP cycles. in_ready deasserts when the 2 buffered codes are waiting behind the active window.
- **Pop timing:** a pop frees a slot in the same cycle; in_ready rises at the next edge.
- **Input stability:** in2..in0 and none_on are sampled only on accepting edges. Values while in_valid = 0 are ignored.

## Test plan

1. **Single code** (HOLD=4, GAP=1): code {0,101} accepted at edge 0 → f = 1 on edges 1..4, out_valid = 1 on edges 1..4, all other lines 0. Idle from edge 5, in_ready = 1 throughout.
2. **none_on code:** code {1,xxx} → h..a = 0, out_valid = 1, none_out = 1 for 4 cycles, then all 0.
3. **Back-pressure:** hold in_valid = 1 with codes 7, 6, 5, 4 on successive accepts.
   - in_ready drops after 3 codes (1 active + 2 buffered).
   - Lines h, g, f, e each pulse for 4 cycles with a 1-cycle gap, in that order.
   - No code is lost or duplicated.
4. **GAP=0, HOLD=1:** codes 0, 1, 2 pushed back-to-back → a, b, c high on consecutive cycles with out_valid continuously 1 for 3 cycles.
5. **Reset mid-operation:** assert rst during cycle 2 of a DRIVE window with 2 codes buffered.
   - All outputs go to 0 immediately (asynchronously).
   - After release: in_ready = 1, no stale pulse appears, and a new code decodes with latency 1.
6. **Push/pop same cycle:** count = 1 at the end of a window while a new code is accepted on the same edge → count stays 1, then both codes replay in order.
